countdown_timer: RTL and testbench

Loadable down-counter with terminal-count event, the down-counting complement of the lab's up-counter. It counts a programmed value down to zero on enabled cycles and raises a latched `done` flag that the consumer must acknowledge. It supports one-shot and auto-reload (periodic tick) modes. It serves as the timing source for debounce windows, display multiplexing and timeouts.

---
 rtl/countdown_timer.sv | 77 +++++++
 tb/tb_countdown_timer.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// Loadable down-counter with latched terminal-count flag, sticky overrun,
// and one-shot or auto-reload (periodic tick) operation.
module countdown_timer #(
  parameter int unsigned bits = 8
) (
  input  logic            CLK,
  input  logic            resetN,
  input  logic            load,
  input  logic [bits-1:0] loadValue,
  input  logic            enable,
  input  logic            autoReload,
  input  logic            ack,
  output logic [bits-1:0] count,
  output logic            busy,
  output logic            done,
  output logic            overrun
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [bits-1:0] count_q, count_d;
  logic [bits-1:0] reload_q, reload_d;
  logic            done_q, done_d;
  logic            ovr_q, ovr_d;

  always_ff @(posedge CLK or negedge resetN) begin
    if (!resetN) begin
      state_q  <= IDLE;
      count_q  <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      reload_q <= reload_d;
      done_q   <= done_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = done_q;
    ovr_d    = ovr_q;
    if (ack) begin
      done_d = 1'b0;
      ovr_d  = 1'b0;
    end
    if (load) begin
      reload_d = loadValue;
      count_d  = loadValue;
      state_d  = (loadValue != '0) ? RUN : IDLE;
    end else if (state_q == RUN && enable) begin
      if (count_q == bits'(1)) begin
        // Terminal event overrides a same-cycle ack; overrun only if unacked.
        done_d = 1'b1;
        if (done_q && !ack) ovr_d = 1'b1;
        count_d = autoReload ? reload_q : '0;
        state_d = autoReload ? RUN : IDLE;
      end else if (count_q > bits'(1)) begin
        count_d = count_q - bits'(1);
      end
    end
  end

  always_comb begin
    count   = count_q;
    busy    = (state_q == RUN);
    done    = done_q;
    overrun = ovr_q;
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer.
module tb_countdown_timer;

  logic       CLK = 1'b0;
  logic       resetN;
  logic       load;
  logic [7:0] loadValue;
  logic       enable;
  logic       autoReload;
  logic       ack;
  logic [7:0] count;
  logic       busy;
  logic       done;
  logic       overrun;

  int total = 0;
  int bad   = 0;

  countdown_timer #(.bits(8)) dut (
    .CLK(CLK), .resetN(resetN), .load(load), .loadValue(loadValue),
    .enable(enable), .autoReload(autoReload), .ack(ack),
    .count(count), .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int c, input int b, input int d, input int o);
    chk({tag, ".count"},   int'(count),   c);
    chk({tag, ".busy"},    int'(busy),    b);
    chk({tag, ".done"},    int'(done),    d);
    chk({tag, ".overrun"}, int'(overrun), o);
  endtask

  initial begin
    int en_seq[6];
    int ex_seq[6];
    en_seq = '{1, 0, 0, 1, 1, 1};
    ex_seq = '{3, 3, 3, 2, 1, 0};

    resetN = 1'b0; load = 1'b0; loadValue = '0; enable = 1'b0;
    autoReload = 1'b0; ack = 1'b0;
    #3;
    chk_all("reset", 0, 0, 0, 0);
    tick(); tick();
    #2 resetN = 1'b1;
    tick();
    chk_all("post_reset", 0, 0, 0, 0);

    // one-shot 5
    load = 1'b1; loadValue = 8'd5; enable = 1'b1;
    tick();
    load = 1'b0;
    chk_all("os_load", 5, 1, 0, 0);
    for (int i = 4; i >= 0; i--) begin
      tick();
      chk("os_count", int'(count), i);
      chk("os_done", int'(done), (i == 0) ? 1 : 0);
      chk("os_busy", int'(busy), (i == 0) ? 0 : 1);
    end
    tick();
    chk_all("os_hold", 0, 0, 1, 0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk_all("os_ack", 0, 0, 0, 0);

    // enable gating
    load = 1'b1; loadValue = 8'd4;
    tick();
    load = 1'b0;
    chk("eg_load", int'(count), 4);
    for (int i = 0; i < 6; i++) begin
      enable = en_seq[i][0];
      tick();
      chk("eg_count", int'(count), ex_seq[i]);
      chk("eg_done", int'(done), (i == 5) ? 1 : 0);
    end
    ack = 1'b1; enable = 1'b1;
    tick();
    ack = 1'b0;
    chk("eg_ack", int'(done), 0);

    // periodic 3 with overrun
    autoReload = 1'b1; load = 1'b1; loadValue = 8'd3;
    tick();
    load = 1'b0;
    chk_all("per_load", 3, 1, 0, 0);
    tick(); chk("per_c2", int'(count), 2);
    tick(); chk_all("per_c1", 1, 1, 0, 0);
    tick(); chk_all("per_ev1", 3, 1, 1, 0);
    tick(); tick();
    chk_all("per_c1b", 1, 1, 1, 0);
    tick(); chk_all("per_ev2", 3, 1, 1, 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk_all("per_ack", 2, 1, 0, 0);

    // load zero from RUN
    load = 1'b1; loadValue = 8'd0;
    tick();
    load = 1'b0;
    chk_all("load0", 0, 0, 0, 0);
    tick();
    chk_all("load0_hold", 0, 0, 0, 0);

    // periodic N=1
    load = 1'b1; loadValue = 8'd1;
    tick();
    load = 1'b0;
    chk_all("n1_load", 1, 1, 0, 0);
    tick(); chk_all("n1_ev1", 1, 1, 1, 0);
    tick(); chk_all("n1_ev2", 1, 1, 1, 1);

    // ack coinciding with terminal count
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk_all("ack_term", 1, 1, 1, 0);

    // load coinciding with terminal count
    load = 1'b1; loadValue = 8'd7;
    tick();
    load = 1'b0;
    chk_all("load_term", 7, 1, 1, 0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk_all("load_term_ack", 6, 1, 0, 0);

    // one-shot 255
    autoReload = 1'b0; load = 1'b1; loadValue = 8'hFF;
    tick();
    load = 1'b0;
    chk("ff_load", int'(count), 255);
    repeat (254) tick();
    chk_all("ff_c1", 1, 1, 0, 0);
    tick();
    chk_all("ff_done", 0, 0, 1, 0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("ff_ack", int'(done), 0);

    // async reset mid-count
    load = 1'b1; loadValue = 8'd10;
    tick();
    load = 1'b0;
    repeat (4) tick();
    chk("ar_pre", int'(count), 6);
    #3 resetN = 1'b0;
    #1;
    chk_all("ar_async", 0, 0, 0, 0);
    #2 resetN = 1'b1;
    repeat (12) tick();
    chk_all("ar_after", 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
